// File: rtl/bin_to_bcd_serial_ctrl.sv
// Serial shift-and-add-3 binary-to-BCD converter, valid/ready on both sides.
// Optional retired-result counter port conv_cnt under BIN2BCD_PERF_CNT_EN.
module bin_to_bcd_serial_ctrl #(
  parameter int NBITS   = 8,
  parameter int NDIGITS = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_val,
  output logic                   in_rdy,
  input  logic [NBITS-1:0]       in,
  output logic                   out_val,
  input  logic                   out_rdy,
  output logic [4*NDIGITS-1:0]   bcd,
  output logic                   busy
`ifdef BIN2BCD_PERF_CNT_EN
  ,
  output logic [15:0]            conv_cnt
`endif
);

  localparam int DW = 4 * NDIGITS;
  localparam int CW = $clog2(NBITS + 1);

  // Bits of each digit that can ever be set for the largest operand.
  function automatic logic [DW-1:0] digit_mask();
    logic [DW-1:0] m;
    longint maxv;
    longint p;
    longint top;
    m    = '0;
    maxv = (64'd1 << NBITS) - 64'd1;
    p    = 64'd1;
    for (int d = 0; d < NDIGITS; d++) begin
      if (p * 64'd10 <= maxv) top = 64'd9;
      else                    top = maxv / p;
      for (int b = 0; b < 4; b++)
        if ((64'd1 << b) <= top) m[4*d+b] = 1'b1;
      p = p * 64'd10;
    end
    return m;
  endfunction

  localparam logic [DW-1:0] MASK = digit_mask();

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [NBITS-1:0]  bin_reg;
  logic [DW-1:0]     dig;
  logic [DW-1:0]     adj;
  logic [CW-1:0]     cnt;

  // Add 3 to every digit that would overflow past 9 after doubling.
  always_comb begin
    adj = dig;
    for (int d = 0; d < NDIGITS; d++)
      if (dig[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = dig[4*d +: 4] + 4'd3;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; SHIFT spends one extra cycle at cnt==0 to publish bcd.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_val)       state_n = SHIFT;
      SHIFT:   if (cnt == '0)    state_n = DONE;
      DONE:    if (out_rdy)      state_n = IDLE;
      default:                   state_n = IDLE;
    endcase
  end

  // Operand load, shift datapath and result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_reg <= '0;
      dig     <= '0;
      cnt     <= '0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            bin_reg <= in;
            dig     <= '0;
            cnt     <= CW'(NBITS);
          end
        end
        SHIFT: begin
          if (cnt != '0) begin
            dig     <= {adj[DW-2:0], bin_reg[NBITS-1]};
            bin_reg <= {bin_reg[NBITS-2:0], 1'b0};
            cnt     <= cnt - 1'b1;
          end else begin
            bcd     <= dig & MASK;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef BIN2BCD_PERF_CNT_EN
  // Saturating count of retired results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      conv_cnt <= '0;
    else if (state == DONE && out_rdy && conv_cnt != 16'hFFFF)
      conv_cnt <= conv_cnt + 16'd1;
  end
`endif

  assign in_rdy  = (state == IDLE);
  assign out_val = (state == DONE);
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_bin_to_bcd_serial_ctrl.sv
// Bench for bin_to_bcd_serial_ctrl: vector table, exhaustive sweep,
// scoreboard queue, backpressure, busy-ignore and mid-op reset.
module tb_bin_to_bcd_serial_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [7:0]  in;
  logic        out_val;
  logic        out_rdy;
  logic [11:0] bcd;
  logic        busy;
`ifdef BIN2BCD_PERF_CNT_EN
  logic [15:0] conv_cnt;
`endif

  bin_to_bcd_serial_ctrl #(.NBITS(8), .NDIGITS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .in      (in),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .bcd     (bcd),
    .busy    (busy)
`ifdef BIN2BCD_PERF_CNT_EN
    ,
    .conv_cnt(conv_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int nres  = 0;
  logic [11:0] q[$];

  typedef struct {
    logic [7:0]  v;
    logic [11:0] e;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Scoreboard: compare every retired result against the queue head.
  always @(negedge clk) begin
    if (rst_n && out_val && out_rdy) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_result: got %0h expected none", bcd);
      end else begin
        logic [11:0] e;
        e = q.pop_front();
        if (bcd !== e) begin
          fails++;
          $display("FAIL result: got %0h expected %0h", bcd, e);
        end
      end
      nres++;
    end
  end

  function automatic logic [11:0] model(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic do_reset();
    rst_n   = 1'b0;
    in_val  = 1'b0;
    in      = '0;
    out_rdy = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    nres = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] v, input logic [11:0] e,
                        input bit push);
    int t;
    t = 0;
    while (!in_rdy && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!in_rdy) chk("in_rdy_timeout", 32'(in_rdy), 32'd1);
    in     = v;
    in_val = 1'b1;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    in_val = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_val && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic run(input logic [7:0] v, input logic [11:0] e);
    int n;
    accept(v, e, 1'b1);
    wait_out(n);
    chk("latency", 32'(n), 32'd9);
    @(posedge clk);
    #1;
    chk("idle_after_retire", 32'(in_rdy), 32'd1);
  endtask

  initial begin
    int n;
    int r0;
    bit seen;

    tbl[0] = '{8'd0,   12'h000};
    tbl[1] = '{8'd1,   12'h001};
    tbl[2] = '{8'd9,   12'h009};
    tbl[3] = '{8'd10,  12'h010};
    tbl[4] = '{8'd99,  12'h099};
    tbl[5] = '{8'd100, 12'h100};
    tbl[6] = '{8'd128, 12'h128};
    tbl[7] = '{8'd255, 12'h255};

    rst_n   = 1'b0;
    in_val  = 1'b0;
    in      = '0;
    out_rdy = 1'b1;
    #12;
    chk("rst_in_rdy",  32'(in_rdy),  32'd1);
    chk("rst_out_val", 32'(out_val), 32'd0);
    chk("rst_bcd",     32'(bcd),     32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
`ifdef BIN2BCD_PERF_CNT_EN
    chk("rst_conv_cnt", 32'(conv_cnt), 32'd0);
`endif
    do_reset();

    for (int i = 0; i < 8; i++) run(tbl[i].v, tbl[i].e);

    for (int i = 0; i < 256; i++) run(8'(i), model(i));

    // Backpressure: result must hold for 5 cycles without retiring.
    out_rdy = 1'b0;
    accept(8'd128, 12'h128, 1'b1);
    wait_out(n);
    chk("bp_latency", 32'(n), 32'd9);
    r0 = nres;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_val", 32'(out_val), 32'd1);
      chk("bp_bcd",     32'(bcd),     32'h128);
`ifdef BIN2BCD_PERF_CNT_EN
      chk("bp_conv_cnt", 32'(conv_cnt), 32'(r0));
`endif
    end
    chk("bp_no_retire", 32'(nres), 32'(r0));
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_in_rdy",   32'(in_rdy),  32'd1);
    chk("bp_out_drop", 32'(out_val), 32'd0);
    chk("bp_retired",  32'(nres),    32'(r0 + 1));

    // in_val during SHIFT must be ignored.
    r0 = nres;
    accept(8'd42, 12'h042, 1'b1);
    in     = 8'd7;
    in_val = 1'b1;
    wait_out(n);
    in_val = 1'b0;
    chk("busy_latency", 32'(n), 32'd9);
    chk("busy_bcd",     32'(bcd), 32'h042);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_one_result", 32'(nres), 32'(r0 + 1));

    // Reset in the middle of a conversion.
    accept(8'd200, 12'h0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_val", 32'(out_val), 32'd0);
    chk("midrst_in_rdy",  32'(in_rdy),  32'd1);
    chk("midrst_busy",    32'(busy),    32'd0);
    q.delete();
    nres = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (out_val) seen = 1'b1;
    end
    chk("midrst_no_out", 32'(seen), 32'd0);
    run(8'd5, 12'h005);

`ifdef BIN2BCD_PERF_CNT_EN
    chk("conv_cnt_model", 32'(conv_cnt), 32'(nres));
    do_reset();
    run(8'd3,   12'h003);
    run(8'd77,  12'h077);
    run(8'd201, 12'h201);
    chk("conv_cnt_three", 32'(conv_cnt), 32'd3);
`endif

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
